// File: rtl/gray_ptr_sync_if.sv
// gray_ptr_sync_if
//   Groups the signals of a Gray pointer synchroniser.
//   master : source/consumer side (drives gray_in, err_clr; receives status)
//   slave  : the synchroniser itself
// Signals:
//   gray_in  [WIDTH] Gray pointer from the source domain (asynchronous)
//   err_clr  [1]     clears the sticky error flag
//   gray_out [WIDTH] synchronised Gray pointer
//   valid    [1]     chain holds only post-reset samples
//   upd      [1]     gray_out changed this cycle
//   err      [1]     sticky multi-bit-step error
interface gray_ptr_sync_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] gray_in;
  logic             err_clr;
  logic [WIDTH-1:0] gray_out;
  logic             valid;
  logic             upd;
  logic             err;

  modport master (
    output gray_in, err_clr,
    input  gray_out, valid, upd, err
  );

  modport slave (
    input  gray_in, err_clr,
    output gray_out, valid, upd, err
  );
endinterface

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync
//   Destination-domain synchroniser for a Gray-coded pointer. A STAGES-deep
//   flop chain resynchronises gray_in; the last stage is presented directly
//   as gray_out. Adds a warm-up valid flag, a per-change update pulse and an
//   optional sticky checker for illegal (multi-bit) Gray steps.
// Configuration:
//   GRAY_PTR_SYNC_CHECK_EN defined   -> multi-bit-step checker and err register
//   GRAY_PTR_SYNC_CHECK_EN undefined -> err tied to 0, err_clr ignored
// Parameters:
//   WIDTH  pointer width (>= 2)
//   STAGES synchroniser depth (>= 2)
// Ports:
//   clk  destination clock, rising edge
//   rst  synchronous active-high reset
//   bus  gray_ptr_sync_if.slave (gray_in, err_clr, gray_out, valid, upd, err)
module gray_ptr_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  gray_ptr_sync_if.slave      bus
);

  localparam int CW = $clog2(STAGES + 1);
  localparam logic [CW-1:0] WCNT_FULL = CW'(STAGES);

  logic [WIDTH-1:0] sync [STAGES];
  logic [WIDTH-1:0] prev;
  logic [CW-1:0]    wcnt;
  logic [CW-1:0]    wcnt_nxt;
  logic             valid_q;

  // Plain flop chain: no logic may sit between stages, otherwise glitches
  // from the asynchronous bus could be captured.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the chain is an array but must still be reset element by
      // element, since reset has to discard every in-flight sample.
      for (int k = 0; k < STAGES; k++) sync[k] <= '0;
      prev <= '0;
    end else begin
      sync[0] <= bus.gray_in;
      for (int k = 1; k < STAGES; k++) sync[k] <= sync[k-1];
      prev <= sync[STAGES-1];
    end
  end

  // Warm-up counter saturates at STAGES. valid is registered from the next
  // count so it rises right after the STAGES-th edge with rst low.
  // NOTE: always_comb outputs get a default first so no latch is inferred.
  always_comb begin
    wcnt_nxt = wcnt;
    if (wcnt != WCNT_FULL) wcnt_nxt = wcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt    <= '0;
      valid_q <= 1'b0;
    end else begin
      wcnt    <= wcnt_nxt;
      valid_q <= (wcnt_nxt == WCNT_FULL);
    end
  end

  assign bus.gray_out = sync[STAGES-1];
  assign bus.valid    = valid_q;
  // Derived from registers only, never from gray_in.
  assign bus.upd      = valid_q & (sync[STAGES-1] != prev);

`ifdef GRAY_PTR_SYNC_CHECK_EN
  logic [WIDTH-1:0] diff;
  logic             step_bad;
  logic             err_q;

  // More than one bit set <=> clearing the lowest set bit leaves a nonzero.
  assign diff     = sync[STAGES-1] ^ prev;
  assign step_bad = valid_q & ((diff & (diff - 1'b1)) != '0);

  // Set has priority over clear so a simultaneous bad step is never lost.
  always_ff @(posedge clk) begin
    if (rst)               err_q <= 1'b0;
    else if (step_bad)     err_q <= 1'b1;
    else if (bus.err_clr)  err_q <= 1'b0;
  end

  assign bus.err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// tb_gray_ptr_sync
//   Directed self-checking bench for gray_ptr_sync (WIDTH=8, STAGES=2).
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point, i.e. after the edge has settled.
module tb_gray_ptr_sync;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

`ifdef GRAY_PTR_SYNC_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;

  gray_ptr_sync_if #(.WIDTH(WIDTH)) bus ();

  gray_ptr_sync #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] bin2gray(input int unsigned b);
    logic [WIDTH-1:0] v;
    v = WIDTH'(b);
    return v ^ (v >> 1);
  endfunction

  initial begin
    int upd_cnt;
    int err_seen;

    rst         = 1'b1;
    bus.gray_in = 8'h00;
    bus.err_clr = 1'b0;

    // Reset release
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_gray_out", bus.gray_out, 0);
      check("rst_valid",    bus.valid,    0);
      check("rst_upd",      bus.upd,      0);
      check("rst_err",      bus.err,      0);
    end
    rst = 1'b0;
    tick();
    check("warm1_valid", bus.valid, 0);
    check("warm1_upd",   bus.upd,   0);
    tick();
    check("warm2_valid",    bus.valid,    1);
    check("warm2_gray_out", bus.gray_out, 0);
    check("warm2_upd",      bus.upd,      0);

    // Single increment
    bus.gray_in = 8'h01;
    tick();
    check("inc_e1_gray_out", bus.gray_out, 8'h00);
    check("inc_e1_upd",      bus.upd,      0);
    tick();
    check("inc_e2_gray_out", bus.gray_out, 8'h01);
    check("inc_e2_upd",      bus.upd,      1);
    check("inc_e2_err",      bus.err,      0);
    tick();
    check("inc_e3_upd", bus.upd, 0);
    check("inc_e3_err", bus.err, 0);

    // Full Gray sequence from code 2 through 255, wrap 0x80->0x00, then 0x01
    upd_cnt  = 0;
    err_seen = 0;
    for (int i = 2; i <= 257; i++) begin
      bus.gray_in = bin2gray(i);
      for (int c = 0; c < 3; c++) begin
        tick();
        if (bus.upd) upd_cnt++;
        if (bus.err) err_seen++;
      end
      if (i == 256) check("wrap_gray_out", bus.gray_out, 8'h00);
    end
    check("seq_upd_count", upd_cnt,      256);
    check("seq_err_cycles", err_seen,    0);
    check("seq_gray_out",  bus.gray_out, 8'h01);

    // Illegal step 0x01 -> 0x07
    bus.gray_in = 8'h07;
    tick();
    check("bad1_e1_upd", bus.upd, 0);
    tick();
    check("bad1_gray_out", bus.gray_out, 8'h07);
    check("bad1_upd",      bus.upd,      1);
    check("bad1_err_pre",  bus.err,      0);
    tick();
    check("bad1_err_set",  bus.err,      ERR_ON);
    check("bad1_upd_off",  bus.upd,      0);
    tick();
    check("bad1_err_hold", bus.err,      ERR_ON);

    // Second bad step 0x07 -> 0x01 with err_clr in the same cycle
    bus.gray_in = 8'h01;
    tick();
    tick();
    check("bad2_upd", bus.upd, 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("bad2_set_wins", bus.err, ERR_ON);
    tick();
    check("bad2_err_hold", bus.err, ERR_ON);

    // Lone err_clr
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("clr_err", bus.err, 0);
    tick();
    check("clr_err_hold", bus.err, 0);

    // Reset mid-operation with gray_in=0x3C held
    bus.gray_in = 8'h3C;
    tick();
    tick();
    check("mid_gray_out", bus.gray_out, 8'h3C);
    check("mid_valid",    bus.valid,    1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_gray_out", bus.gray_out, 0);
    check("mrst_valid",    bus.valid,    0);
    check("mrst_upd",      bus.upd,      0);
    check("mrst_err",      bus.err,      0);
    tick();
    check("mrel1_gray_out", bus.gray_out, 0);
    check("mrel1_valid",    bus.valid,    0);
    tick();
    check("mrel2_gray_out", bus.gray_out, 8'h3C);
    check("mrel2_valid",    bus.valid,    1);
    check("mrel2_upd",      bus.upd,      1);
    tick();
    check("mrel3_upd", bus.upd, 0);
    check("mrel3_err", bus.err, ERR_ON);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
